// File: rtl/fluxo_dados_drone.sv
// fluxo_dados_drone - datapath for the drone game control unit.
// Holds the step timer, map scroll position, drone lane, obstacle ROM and
// collision check. Also synchronises and edge-detects the up/down buttons.
//
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   zeraPosicoes        clear map position, force lane to 1
//   contaT, zeraT       step timer count enable / synchronous clear
//   desloca             advance map position (saturating at MAP_LEN-1)
//   botao_cima/baixo    raw asynchronous button levels
//   fim_espera          timer at terminal count (combinational)
//   fim_mapa            position at last column (combinational)
//   colisao             obstacle at (position, lane) (combinational)
//   db_posicao/linha/obstaculos   debug views of position, lane, column mask
//
// Latency: strobes take effect at the next edge; a button level rising before
// edge k moves the lane at edge k+3. Status outputs are combinational from state.
// No backpressure: control strobes are trusted and applied as given.

module fluxo_dados_drone #(
    parameter int T_ESPERA = 25000000,
    parameter int MAP_LEN  = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       zeraPosicoes,
    input  logic       contaT,
    input  logic       zeraT,
    input  logic       desloca,
    input  logic       botao_cima,
    input  logic       botao_baixo,
    output logic       fim_espera,
    output logic       fim_mapa,
    output logic       colisao,
    output logic [3:0] db_posicao,
    output logic [1:0] db_linha,
    output logic [3:0] db_obstaculos
);

    localparam logic [25:0] TIMER_MAX = 26'(T_ESPERA - 1);
    localparam logic [3:0]  POS_MAX   = 4'(MAP_LEN - 1);

    logic [25:0] r_timer;
    logic [3:0]  r_posicao;
    logic [1:0]  r_linha;

    // Button path: two-flop synchroniser, previous-value register, and a
    // registered press pulse (the pulse register gives the k+3 move latency).
    logic r_cima_s1, r_cima_s2, r_cima_prev, r_cima_press;
    logic r_baixo_s1, r_baixo_s2, r_baixo_prev, r_baixo_press;

    logic [3:0] w_obstaculos;
    logic       w_sobe;
    logic       w_desce;

    // ---------------------------------------------------------------- timer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
        end else if (zeraT) begin
            r_timer <= '0;
        end else if (contaT) begin
            if (r_timer == TIMER_MAX) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 26'd1;
            end
        end
    end

    assign fim_espera = (r_timer == TIMER_MAX);

    // ------------------------------------------------------------- position
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_posicao <= '0;
        end else if (zeraPosicoes) begin
            r_posicao <= '0;
        end else if (desloca && (r_posicao != POS_MAX)) begin
            r_posicao <= r_posicao + 4'd1;
        end
    end

    assign fim_mapa = (r_posicao == POS_MAX);

    // -------------------------------------------------------------- buttons
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cima_s1     <= 1'b0;
            r_cima_s2     <= 1'b0;
            r_cima_prev   <= 1'b0;
            r_cima_press  <= 1'b0;
            r_baixo_s1    <= 1'b0;
            r_baixo_s2    <= 1'b0;
            r_baixo_prev  <= 1'b0;
            r_baixo_press <= 1'b0;
        end else begin
            r_cima_s1     <= botao_cima;
            r_cima_s2     <= r_cima_s1;
            r_cima_prev   <= r_cima_s2;
            r_cima_press  <= r_cima_s2 & ~r_cima_prev;
            r_baixo_s1    <= botao_baixo;
            r_baixo_s2    <= r_baixo_s1;
            r_baixo_prev  <= r_baixo_s2;
            r_baixo_press <= r_baixo_s2 & ~r_baixo_prev;
        end
    end

    // Presses in the same cycle cancel each other.
    assign w_sobe  = r_cima_press & ~r_baixo_press;
    assign w_desce = r_baixo_press & ~r_cima_press;

    // ----------------------------------------------------------------- lane
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_linha <= 2'd1;
        end else if (zeraPosicoes) begin
            r_linha <= 2'd1;
        end else if (w_sobe && (r_linha != 2'd3)) begin
            r_linha <= r_linha + 2'd1;
        end else if (w_desce && (r_linha != 2'd0)) begin
            r_linha <= r_linha - 2'd1;
        end
    end

    // ---------------------------------------------------------- obstacle ROM
    // Bit i of a column mask set means lane i is blocked.
    always_comb begin
        w_obstaculos = 4'h0;
        case (r_posicao)
            4'd0:  w_obstaculos = 4'h0;
            4'd1:  w_obstaculos = 4'h0;
            4'd2:  w_obstaculos = 4'h1;
            4'd3:  w_obstaculos = 4'h8;
            4'd4:  w_obstaculos = 4'h2;
            4'd5:  w_obstaculos = 4'h4;
            4'd6:  w_obstaculos = 4'h9;
            4'd7:  w_obstaculos = 4'h0;
            4'd8:  w_obstaculos = 4'h6;
            4'd9:  w_obstaculos = 4'h1;
            4'd10: w_obstaculos = 4'hC;
            4'd11: w_obstaculos = 4'h2;
            4'd12: w_obstaculos = 4'h5;
            4'd13: w_obstaculos = 4'h8;
            4'd14: w_obstaculos = 4'h3;
            4'd15: w_obstaculos = 4'h0;
            default: w_obstaculos = 4'h0;
        endcase
    end

    assign colisao       = w_obstaculos[r_linha];
    assign db_obstaculos = w_obstaculos;
    assign db_posicao    = r_posicao;
    assign db_linha      = r_linha;

endmodule
